// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB tag wakeup and lowest-index-first dispatch.
// Define ALU_RS_BYPASS_EN to let a ready issue go straight to exec when the buffer has nothing ready.
module alu_rs #(
  parameter int RS_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [5:0]  issue_op,
  input  logic [31:0] issue_vj,
  input  logic [3:0]  issue_qj,
  input  logic        issue_qj_pend,
  input  logic [31:0] issue_vk,
  input  logic [3:0]  issue_qk,
  input  logic        issue_qk_pend,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_imm,
  input  logic [3:0]  issue_rob_id,
  output logic        full,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_rob_id,
  input  logic [31:0] cdb_value,
  output logic        exec_valid,
  output logic [5:0]  exec_op,
  output logic [31:0] exec_rs,
  output logic [31:0] exec_rt,
  output logic [31:0] exec_pc,
  output logic [31:0] exec_imm,
  output logic [3:0]  exec_rob_id
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_pend_q, qj_pend_d;
  logic [RS_SIZE-1:0] qk_pend_q, qk_pend_d;
  logic [5:0]         op_q     [RS_SIZE];
  logic [5:0]         op_d     [RS_SIZE];
  logic [31:0]        vj_q     [RS_SIZE];
  logic [31:0]        vj_d     [RS_SIZE];
  logic [3:0]         qj_q     [RS_SIZE];
  logic [3:0]         qj_d     [RS_SIZE];
  logic [31:0]        vk_q     [RS_SIZE];
  logic [31:0]        vk_d     [RS_SIZE];
  logic [3:0]         qk_q     [RS_SIZE];
  logic [3:0]         qk_d     [RS_SIZE];
  logic [31:0]        pc_q     [RS_SIZE];
  logic [31:0]        pc_d     [RS_SIZE];
  logic [31:0]        imm_q    [RS_SIZE];
  logic [31:0]        imm_d    [RS_SIZE];
  logic [3:0]         rob_id_q [RS_SIZE];
  logic [3:0]         rob_id_d [RS_SIZE];

  logic        exec_valid_q, exec_valid_d;
  logic [5:0]  exec_op_q, exec_op_d;
  logic [31:0] exec_rs_q, exec_rs_d;
  logic [31:0] exec_rt_q, exec_rt_d;
  logic [31:0] exec_pc_q, exec_pc_d;
  logic [31:0] exec_imm_q, exec_imm_d;
  logic [3:0]  exec_rob_id_q, exec_rob_id_d;

  logic [RS_SIZE-1:0] ready;
  logic               disp_found;
  logic [IDX_W-1:0]   disp_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [31:0]        iss_vj, iss_vk;
  logic               iss_qj_pend, iss_qk_pend;
  logic               bypass_en, bypass_take, issue_take;

`ifdef ALU_RS_BYPASS_EN
  assign bypass_en = 1'b1;
`else
  assign bypass_en = 1'b0;
`endif

  assign full  = &busy_q;
  assign ready = busy_q & ~qj_pend_q & ~qk_pend_q;

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // A tag broadcast on the issue edge is captured before the op lands anywhere.
  always_comb begin
    iss_vj      = issue_vj;
    iss_qj_pend = issue_qj_pend;
    iss_vk      = issue_vk;
    iss_qk_pend = issue_qk_pend;
    if (cdb_valid && issue_qj_pend && (issue_qj == cdb_rob_id)) begin
      iss_vj      = cdb_value;
      iss_qj_pend = 1'b0;
    end
    if (cdb_valid && issue_qk_pend && (issue_qk == cdb_rob_id)) begin
      iss_vk      = cdb_value;
      iss_qk_pend = 1'b0;
    end
  end

  assign bypass_take = bypass_en & issue_valid & free_found & ~disp_found
                       & ~iss_qj_pend & ~iss_qk_pend;
  assign issue_take  = issue_valid & free_found & ~bypass_take;

  always_comb begin
    busy_d        = busy_q;
    qj_pend_d     = qj_pend_q;
    qk_pend_d     = qk_pend_q;
    op_d          = op_q;
    vj_d          = vj_q;
    qj_d          = qj_q;
    vk_d          = vk_q;
    qk_d          = qk_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rob_id_d      = rob_id_q;
    exec_valid_d  = exec_valid_q;
    exec_op_d     = exec_op_q;
    exec_rs_d     = exec_rs_q;
    exec_rt_d     = exec_rt_q;
    exec_pc_d     = exec_pc_q;
    exec_imm_d    = exec_imm_q;
    exec_rob_id_d = exec_rob_id_q;

    if (rdy) begin
      if (flush) begin
        busy_d       = '0;
        exec_valid_d = 1'b0;
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qj_pend_q[i] && (qj_q[i] == cdb_rob_id)) begin
              vj_d[i]      = cdb_value;
              qj_pend_d[i] = 1'b0;
            end
            if (busy_q[i] && qk_pend_q[i] && (qk_q[i] == cdb_rob_id)) begin
              vk_d[i]      = cdb_value;
              qk_pend_d[i] = 1'b0;
            end
          end
        end

        // The free slot is never the dispatching slot, so both may update together.
        if (issue_take) begin
          busy_d[free_idx]    = 1'b1;
          op_d[free_idx]      = issue_op;
          vj_d[free_idx]      = iss_vj;
          qj_d[free_idx]      = issue_qj;
          qj_pend_d[free_idx] = iss_qj_pend;
          vk_d[free_idx]      = iss_vk;
          qk_d[free_idx]      = issue_qk;
          qk_pend_d[free_idx] = iss_qk_pend;
          pc_d[free_idx]      = issue_pc;
          imm_d[free_idx]     = issue_imm;
          rob_id_d[free_idx]  = issue_rob_id;
        end

        if (disp_found) begin
          busy_d[disp_idx] = 1'b0;
          exec_valid_d     = 1'b1;
          exec_op_d        = op_q[disp_idx];
          exec_rs_d        = vj_q[disp_idx];
          exec_rt_d        = vk_q[disp_idx];
          exec_pc_d        = pc_q[disp_idx];
          exec_imm_d       = imm_q[disp_idx];
          exec_rob_id_d    = rob_id_q[disp_idx];
        end else if (bypass_take) begin
          exec_valid_d  = 1'b1;
          exec_op_d     = issue_op;
          exec_rs_d     = iss_vj;
          exec_rt_d     = iss_vk;
          exec_pc_d     = issue_pc;
          exec_imm_d    = issue_imm;
          exec_rob_id_d = issue_rob_id;
        end else begin
          exec_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      exec_valid_q  <= 1'b0;
      exec_op_q     <= '0;
      exec_rs_q     <= '0;
      exec_rt_q     <= '0;
      exec_pc_q     <= '0;
      exec_imm_q    <= '0;
      exec_rob_id_q <= '0;
    end else begin
      busy_q        <= busy_d;
      exec_valid_q  <= exec_valid_d;
      exec_op_q     <= exec_op_d;
      exec_rs_q     <= exec_rs_d;
      exec_rt_q     <= exec_rt_d;
      exec_pc_q     <= exec_pc_d;
      exec_imm_q    <= exec_imm_d;
      exec_rob_id_q <= exec_rob_id_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    qj_pend_q <= qj_pend_d;
    qk_pend_q <= qk_pend_d;
    op_q      <= op_d;
    vj_q      <= vj_d;
    qj_q      <= qj_d;
    vk_q      <= vk_d;
    qk_q      <= qk_d;
    pc_q      <= pc_d;
    imm_q     <= imm_d;
    rob_id_q  <= rob_id_d;
  end

  assign exec_valid  = exec_valid_q;
  assign exec_op     = exec_op_q;
  assign exec_rs     = exec_rs_q;
  assign exec_rt     = exec_rt_q;
  assign exec_pc     = exec_pc_q;
  assign exec_imm    = exec_imm_q;
  assign exec_rob_id = exec_rob_id_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: scoreboard bench for alu_rs; a reference model queues expected dispatches,
// a monitor pops them whenever exec_valid appears after an active edge.
module tb_alu_rs;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk, issue_pc, issue_imm;
  logic [3:0]  issue_qj, issue_qk, issue_rob_id;
  logic        issue_qj_pend, issue_qk_pend;
  logic        full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic        exec_valid;
  logic [5:0]  exec_op;
  logic [31:0] exec_rs, exec_rt, exec_pc, exec_imm;
  logic [3:0]  exec_rob_id;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_pend(issue_qj_pend),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_pend(issue_qk_pend),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_rob_id(issue_rob_id),
    .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .exec_valid(exec_valid), .exec_op(exec_op), .exec_rs(exec_rs), .exec_rt(exec_rt),
    .exec_pc(exec_pc), .exec_imm(exec_imm), .exec_rob_id(exec_rob_id)
  );

  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vj;
    logic [3:0]  qj;
    bit          qjp;
    logic [31:0] vk;
    logic [3:0]  qk;
    bit          qkp;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
  } ent_t;

  typedef struct {
    int          edge_no;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
  } exp_t;

  ent_t m_ent [N];
  exp_t sb [$];
  int   edge_cnt = 0;
  bit   m_exec_valid = 1'b0;
  bit   m_full = 1'b0;
  bit   m_last_active = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: one step of the station per clock edge, built from plain entry records.
  always @(posedge clk) begin
    int          d, f;
    bit          full_now, byp, jp, kp;
    logic [31:0] jv, kv;
    exp_t        e;
    edge_cnt++;
    m_last_active = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
      m_exec_valid = 1'b0;
    end else if (rdy) begin
      m_last_active = 1'b1;
      if (flush) begin
        for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
        m_exec_valid = 1'b0;
      end else begin
        d = -1; f = -1; full_now = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (!m_ent[i].busy) begin
            full_now = 1'b0;
            if (f < 0) f = i;
          end else if (!m_ent[i].qjp && !m_ent[i].qkp && d < 0) begin
            d = i;
          end
        end
        jp = issue_qj_pend; jv = issue_vj;
        kp = issue_qk_pend; kv = issue_vk;
        if (cdb_valid && jp && issue_qj == cdb_rob_id) begin jp = 1'b0; jv = cdb_value; end
        if (cdb_valid && kp && issue_qk == cdb_rob_id) begin kp = 1'b0; kv = cdb_value; end
        byp = 1'b0;
`ifdef ALU_RS_BYPASS_EN
        byp = issue_valid && !full_now && d < 0 && !jp && !kp;
`endif
        if (cdb_valid) begin
          for (int i = 0; i < N; i++) begin
            if (m_ent[i].busy && m_ent[i].qjp && m_ent[i].qj == cdb_rob_id) begin
              m_ent[i].qjp = 1'b0; m_ent[i].vj = cdb_value;
            end
            if (m_ent[i].busy && m_ent[i].qkp && m_ent[i].qk == cdb_rob_id) begin
              m_ent[i].qkp = 1'b0; m_ent[i].vk = cdb_value;
            end
          end
        end
        if (d >= 0) begin
          e.edge_no = edge_cnt; e.op = m_ent[d].op; e.rs = m_ent[d].vj; e.rt = m_ent[d].vk;
          e.pc = m_ent[d].pc; e.imm = m_ent[d].imm; e.rob = m_ent[d].rob;
          sb.push_back(e);
          m_ent[d].busy = 1'b0;
          m_exec_valid = 1'b1;
        end else if (byp) begin
          e.edge_no = edge_cnt; e.op = issue_op; e.rs = jv; e.rt = kv;
          e.pc = issue_pc; e.imm = issue_imm; e.rob = issue_rob_id;
          sb.push_back(e);
          m_exec_valid = 1'b1;
        end else begin
          m_exec_valid = 1'b0;
        end
        if (issue_valid && !full_now && !byp) begin
          m_ent[f].busy = 1'b1; m_ent[f].op = issue_op;
          m_ent[f].vj = jv; m_ent[f].qj = issue_qj; m_ent[f].qjp = jp;
          m_ent[f].vk = kv; m_ent[f].qk = issue_qk; m_ent[f].qkp = kp;
          m_ent[f].pc = issue_pc; m_ent[f].imm = issue_imm; m_ent[f].rob = issue_rob_id;
        end
      end
    end
    m_full = 1'b1;
    for (int i = 0; i < N; i++) if (!m_ent[i].busy) m_full = 1'b0;
  end

  // Monitor: compares status every cycle and pops the scoreboard on each fresh dispatch.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_output("exec_valid", 32'(exec_valid), 32'(m_exec_valid));
      check_output("full", 32'(full), 32'(m_full));
      if (exec_valid && m_last_active) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_dispatch: got rob %0d expected none (t=%0t)", exec_rob_id, $time);
        end else begin
          e = sb.pop_front();
          check_output("disp_edge", 32'(edge_cnt), 32'(e.edge_no));
          check_output("exec_op", 32'(exec_op), 32'(e.op));
          check_output("exec_rs", exec_rs, e.rs);
          check_output("exec_rt", exec_rt, e.rt);
          check_output("exec_pc", exec_pc, e.pc);
          check_output("exec_imm", exec_imm, e.imm);
          check_output("exec_rob_id", 32'(exec_rob_id), 32'(e.rob));
        end
      end
    end
  end

  // One clock edge, then drop the single-cycle pulses.
  task automatic apply_stimulus();
    @(negedge clk);
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic qjp,
                           input logic [3:0] qj, input logic [31:0] vk, input logic qkp,
                           input logic [3:0] qk, input logic [3:0] rob);
    issue_valid = 1'b1; issue_op = op;
    issue_vj = vj; issue_qj_pend = qjp; issue_qj = qj;
    issue_vk = vk; issue_qk_pend = qkp; issue_qk = qk;
    issue_pc = $urandom; issue_imm = $urandom; issue_rob_id = rob;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob_id = tag; cdb_value = val;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_vj = '0; issue_vk = '0; issue_pc = '0; issue_imm = '0;
    issue_qj = '0; issue_qk = '0; issue_rob_id = '0; issue_qj_pend = 1'b0; issue_qk_pend = 1'b0;
    cdb_valid = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    repeat (2) @(negedge clk);

    // Reset applies even with rdy low.
    check_output("rst_exec_valid", 32'(exec_valid), 32'd0);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_exec_op", 32'(exec_op), 32'd0);
    check_output("rst_exec_rs", exec_rs, 32'd0);
    check_output("rst_exec_rt", exec_rt, 32'd0);
    check_output("rst_exec_pc", exec_pc, 32'd0);
    check_output("rst_exec_imm", exec_imm, 32'd0);
    check_output("rst_exec_rob", 32'(exec_rob_id), 32'd0);
    rst = 1'b0; rdy = 1'b1; mon_en = 1'b1;

    // Both operands ready: dispatch one edge after issue (same edge with bypass).
    set_issue(6'h01, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    apply_stimulus();
`ifndef ALU_RS_BYPASS_EN
    check_output("add_no_early", 32'(exec_valid), 32'd0);
    apply_stimulus();
`endif
    check_output("add_valid", 32'(exec_valid), 32'd1);
    check_output("add_rs", exec_rs, 32'd5);
    check_output("add_rt", exec_rt, 32'd7);
    check_output("add_rob", 32'(exec_rob_id), 32'd3);
    apply_stimulus();
    check_output("add_one_cycle", 32'(exec_valid), 32'd0);

    // qj pending on tag 2, broadcast two edges later.
    set_issue(6'h02, 32'hAAAA, 1'b1, 4'd2, 32'h11, 1'b0, 4'd0, 4'd4);
    apply_stimulus();
    check_output("wait_e0", 32'(exec_valid), 32'd0);
    apply_stimulus();
    check_output("wait_e1", 32'(exec_valid), 32'd0);
    set_cdb(4'd2, 32'h1234);
    apply_stimulus();
    check_output("wait_e2", 32'(exec_valid), 32'd0);
    apply_stimulus();
    check_output("wake_valid", 32'(exec_valid), 32'd1);
    check_output("wake_rs", exec_rs, 32'h1234);
    apply_stimulus();

    // Broadcast on the issue edge must be captured.
    set_issue(6'h03, 32'h21, 1'b0, 4'd0, 32'hDEAD, 1'b1, 4'd6, 4'd5);
    set_cdb(4'd6, 32'd9);
    apply_stimulus();
`ifndef ALU_RS_BYPASS_EN
    check_output("same_edge_wait", 32'(exec_valid), 32'd0);
    apply_stimulus();
`endif
    check_output("same_edge_valid", 32'(exec_valid), 32'd1);
    check_output("same_edge_rt", exec_rt, 32'd9);
    apply_stimulus();

    // Fill all entries waiting on tag 1, overflow issue ignored, then drain in order.
    for (int k = 0; k < N; k++) begin
      set_issue(6'h04, 32'(k), 1'b1, 4'd1, 32'(k + 100), 1'b0, 4'd0, 4'(k));
      apply_stimulus();
    end
    check_output("fill_full", 32'(full), 32'd1);
    set_issue(6'h05, 32'd99, 1'b0, 4'd0, 32'd99, 1'b0, 4'd0, 4'd9);
    apply_stimulus();
    check_output("overflow_full", 32'(full), 32'd1);
    check_output("overflow_no_disp", 32'(exec_valid), 32'd0);
    set_cdb(4'd1, 32'h55);
    apply_stimulus();
    check_output("bcast_full", 32'(full), 32'd1);
    for (int k = 0; k < N; k++) begin
      apply_stimulus();
      check_output("drain_valid", 32'(exec_valid), 32'd1);
      check_output("drain_rob", 32'(exec_rob_id), 32'(k));
      check_output("drain_rt", exec_rt, 32'(k + 100));
      if (k == 0) check_output("drain_full_fall", 32'(full), 32'd0);
    end
    apply_stimulus();
    check_output("drain_done", 32'(exec_valid), 32'd0);

    // Flush with three parked entries and a simultaneous ready issue.
    for (int k = 0; k < 3; k++) begin
      set_issue(6'h06, 32'd1, 1'b1, 4'd15, 32'd2, 1'b0, 4'd0, 4'(k + 10));
      apply_stimulus();
    end
    set_issue(6'h07, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd13);
    flush = 1'b1;
    apply_stimulus();
    check_output("flush_full", 32'(full), 32'd0);
    check_output("flush_valid", 32'(exec_valid), 32'd0);
    set_cdb(4'd15, 32'h77);
    apply_stimulus();
    repeat (4) apply_stimulus();
    check_output("flush_no_disp", 32'(exec_valid), 32'd0);

    // Ready entry held through three rdy=0 edges.
    set_issue(6'h08, 32'd0, 1'b1, 4'd8, 32'd1, 1'b0, 4'd0, 4'd7);
    apply_stimulus();
    set_cdb(4'd8, 32'h33);
    apply_stimulus();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus();
      check_output("stall_valid", 32'(exec_valid), 32'd0);
      check_output("stall_full", 32'(full), 32'd0);
    end
    rdy = 1'b1;
    apply_stimulus();
    check_output("unstall_valid", 32'(exec_valid), 32'd1);
    check_output("unstall_rs", exec_rs, 32'h33);
    check_output("unstall_rob", 32'(exec_rob_id), 32'd7);
    apply_stimulus();

    // Reset on the edge where a ready entry would dispatch.
    set_issue(6'h09, 32'd11, 1'b0, 4'd0, 32'd12, 1'b0, 4'd0, 4'd2);
    apply_stimulus();
    rst = 1'b1;
    apply_stimulus();
    check_output("midrst_valid", 32'(exec_valid), 32'd0);
    check_output("midrst_rs", exec_rs, 32'd0);
    apply_stimulus();
    check_output("midrst_no_disp", 32'(exec_valid), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) != 0)
        set_issue(6'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) != 0)
        set_cdb(4'($urandom_range(0, 15)), $urandom);
      apply_stimulus();
    end

    // Wake every tag and let the buffer empty.
    rdy = 1'b1;
    for (int t = 0; t < 16; t++) begin
      set_cdb(4'(t), $urandom);
      apply_stimulus();
    end
    repeat (20) apply_stimulus();
    check_output("final_full", 32'(full), 32'd0);
    check_output("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 synchronous active-high reset; rdy in 1 global enable.
REQ-003 SHALL have flush in 1 mispredict flush.
REQ-004 SHALL have issue_valid in 1; issue_op in 6; issue_vj in 32; issue_qj in 4; issue_qj_pend in 1; issue_vk in 32; issue_qk in 4; issue_qk_pend in 1; issue_pc in 32; issue_imm in 32; issue_rob_id in 4 (the new-instruction port from the decoder).
REQ-005 SHALL have full out 1: no free entry.
REQ-006 SHALL have cdb_valid in 1; cdb_rob_id in 4; cdb_value in 32 (the result-broadcast port).
REQ-007 SHALL have exec_valid out 1; exec_op out 6; exec_rs out 32; exec_rt out 32; exec_pc out 32; exec_imm out 32; exec_rob_id out 4 (the registered operation port feeding the ALU).

Function
REQ-008 SHALL hold per entry: busy, op, vj, qj, qj_pend, vk, qk, qk_pend, pc, imm, rob_id.
REQ-009 SHALL drive full combinationally, high iff all RS_SIZE entries are busy, from current state only; a same-edge dispatch does not lower it.
REQ-010 SHALL, on an edge with rdy=1 and issue_valid=1 and full=0, write the issue fields into the lowest-index non-busy entry and set busy.
REQ-011 SHALL ignore issue_valid while full=1; the issuer must not assert it then.
REQ-012 SHALL, on an edge with cdb_valid=1, set vj=cdb_value and clear qj_pend in every busy entry with qj_pend=1 and qj=cdb_rob_id; identically for vk/qk.
REQ-013 SHALL apply the REQ-012 capture to the entry being issued on that same edge, so a tag broadcast in the issue cycle is never lost.
REQ-014 SHALL treat an entry as ready iff busy=1, qj_pend=0, and qk_pend=0, evaluated on registered state; wakeup on edge E makes the entry dispatchable at edge E+1.
REQ-015 SHALL, on every edge with rdy=1, select the lowest-index ready entry, load its op/vj/vk/pc/imm/rob_id into exec_op/exec_rs/exec_rt/exec_pc/exec_imm/exec_rob_id, set exec_valid=1, and clear that entry's busy.
REQ-016 SHALL set exec_valid=0 on an edge with rdy=1 when no entry is ready, with exec_valid thereby high for exactly one cycle per dispatched op; exec_* data holds its last value.
REQ-017 SHALL dispatch at most one op per cycle, and issue, wakeup, and dispatch of different entries SHALL all be able to occur on the same edge.
REQ-018 SHALL give minimum latency, without the REQ-026 bypass, of exec_valid high in the cycle after the issue edge plus one: an issue at edge E0 with ready operands dispatches at edge E1.
REQ-019 SHALL, on an edge with rdy=1 and flush=1, clear all busy bits and exec_valid and ignore the issue and CDB inputs that edge, with flush taking priority over all other actions.
REQ-020 SHALL, with rdy=0, change no state (entries and exec_* hold, including exec_valid); issue and CDB inputs are ignored.

Reset
REQ-021 SHALL, on rst=1 at an edge, regardless of rdy, clear all busy bits and set exec_valid=0 and exec_op/exec_rs/exec_rt/exec_pc/exec_imm/exec_rob_id=0.
REQ-022 SHALL, on rst mid-operation, discard all pending entries, and no dispatch SHALL occur on the reset edge.
REQ-023 SHALL drive full=0 in the cycle after reset.

Configuration
REQ-024 SHALL provide macro ALU_RS_BYPASS_EN to enable direct issue-to-exec bypass.
REQ-025 SHALL, without ALU_RS_BYPASS_EN, route every op through an entry per REQ-018.
REQ-026 SHALL, with ALU_RS_BYPASS_EN, on an edge with rdy=1, issue_valid=1, full=0, no ready entry in the buffer, and both operands available (pend=0 or captured per REQ-013), load the issue fields directly into exec_* with exec_valid=1 and allocate no entry (zero-cycle buffer latency).
REQ-027 SHALL, with ALU_RS_BYPASS_EN, otherwise behave per REQ-010..REQ-018, with buffered ready entries always taking priority over bypass.

Verification
REQ-028 SHALL cover: issue op=ADD vj=5 vk=7 both ready, rob_id=3 at E0 -> exec_valid high for one cycle after E1, exec_rs=5, exec_rt=7, exec_rob_id=3 (with ALU_RS_BYPASS_EN: after E0).
REQ-029 SHALL cover: issue with qj=2 pending; cdb rob_id=2 value=0x1234 at E2 -> no exec_valid before E3; after E3 exec_rs=0x1234.
REQ-030 SHALL cover: issue with qk=6 pending while cdb_valid rob_id=6 value=9 on the same edge -> entry ready next cycle, exec_rt=9.
REQ-031 SHALL cover: issue 8 ops all pending on tag 1 -> full=1; 9th issue_valid is ignored; cdb tag 1 -> 8 dispatches on consecutive edges in entry order 0..7, and full falls after the first dispatch.
REQ-032 SHALL cover: 3 busy entries, then flush=1 with a simultaneous issue -> next cycle full=0, exec_valid=0, and no later dispatch of any of the 4 ops.
REQ-033 SHALL cover: rdy=0 for 3 cycles with a ready entry -> exec_valid and all state frozen; dispatch on the first edge with rdy=1.
